// File: rtl/bitrev_reorder_buf_pkg.sv
// Shared FFT definitions: frame geometry defaults, storage entry layout and
// the bit-reversal helper used to address the reorder banks.
package bitrev_reorder_buf_pkg;

  localparam int DEF_N_FFT  = 512;
  localparam int DEF_NCHAN  = 16;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_IDX_W  = 5;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
    logic signed [DEF_IDX_W-1:0]  idx;
  } entry_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned nbits);
    logic [31:0] y;
    y = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      y[i] = x[nbits-1-i];
    end
    return y;
  endfunction

endpackage

// File: rtl/bitrev_reorder_buf_bank.sv
// One ping-pong bank: a full NCHAN-wide beat written per cycle, NCHAN
// independent asynchronous read ports addressed by sample position.
module reorder_bank
  import bitrev_reorder_buf_pkg::*;
#(
  parameter int DEPTH = DEF_N_FFT,
  parameter int NCHAN = DEF_NCHAN,
  parameter int W     = $bits(entry_t),
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = $clog2(DEPTH / NCHAN)
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [BW-1:0]             i_wbeat,
  input  logic [NCHAN-1:0][W-1:0]   i_wdata,
  input  logic [NCHAN-1:0][AW-1:0]  i_raddr,
  output logic [NCHAN-1:0][W-1:0]   o_rdata
);

  localparam int LANE_W = $clog2(NCHAN);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned l = 0; l < NCHAN; l++) begin
        r_mem[{i_wbeat, LANE_W'(l)}] <= i_wdata[l];
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < NCHAN; l++) begin
      o_rdata[l] = r_mem[i_raddr[l]];
    end
  end

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Natural-order to bit-reversed-order frame reorder buffer: ping-pong banks,
// writes fill one bank while the read FSM drains the other, outputs registered.
module bitrev_reorder_buf
  import bitrev_reorder_buf_pkg::*;
#(
  parameter int N_FFT  = DEF_N_FFT,
  parameter int NCHAN  = DEF_NCHAN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  valid_in,
  input  logic signed [NCHAN-1:0][DATA_W-1:0]   data_re_in,
  input  logic signed [NCHAN-1:0][DATA_W-1:0]   data_im_in,
  input  logic signed [NCHAN-1:0][IDX_W-1:0]    idx_in,
  output logic signed [NCHAN-1:0][DATA_W-1:0]   data_re_out,
  output logic signed [NCHAN-1:0][DATA_W-1:0]   data_im_out,
  output logic signed [NCHAN-1:0][IDX_W-1:0]    idx_out,
  output logic                                  valid_out,
  output logic                                  sof_out
);

  localparam int BEATS   = N_FFT / NCHAN;
  localparam int LOG2N   = $clog2(N_FFT);
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int LANE_W  = $clog2(NCHAN);
  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  rd_state_e             r_state, w_state_nxt;
  logic [BEAT_W-1:0]     r_wr_cnt, r_rd_cnt, w_rd_cnt_nxt;
  logic                  r_wr_bank, r_rd_bank, w_rd_bank_nxt;
  logic [1:0]            r_ready, w_ready_nxt;
  logic                  w_rd_done, w_wr_last;

  entry_t                          w_wr_e [NCHAN];
  entry_t                          w_rd_e [NCHAN];
  logic [NCHAN-1:0][ENTRY_W-1:0]   w_wr_data, w_rd0, w_rd1;
  logic [NCHAN-1:0][LOG2N-1:0]     w_raddr;

  logic                                 r_valid_out, r_sof_out;
  logic signed [NCHAN-1:0][DATA_W-1:0]  r_re_out, r_im_out;
  logic signed [NCHAN-1:0][IDX_W-1:0]   r_idx_out;

  assign w_wr_last = valid_in && (r_wr_cnt == LAST_BEAT);

  always_comb begin
    for (int unsigned l = 0; l < NCHAN; l++) begin
      w_wr_e[l].re  = data_re_in[l];
      w_wr_e[l].im  = data_im_in[l];
      w_wr_e[l].idx = idx_in[l];
      w_wr_data[l]  = w_wr_e[l];
      w_raddr[l]    = LOG2N'(bitrev(32'({r_rd_cnt, LANE_W'(l)}), LOG2N));
    end
  end

  reorder_bank #(
    .DEPTH (N_FFT),
    .NCHAN (NCHAN),
    .W     (ENTRY_W)
  ) u_bank0 (
    .i_clk   (clk),
    .i_we    (valid_in && !r_wr_bank),
    .i_wbeat (r_wr_cnt),
    .i_wdata (w_wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rd0)
  );

  reorder_bank #(
    .DEPTH (N_FFT),
    .NCHAN (NCHAN),
    .W     (ENTRY_W)
  ) u_bank1 (
    .i_clk   (clk),
    .i_we    (valid_in && r_wr_bank),
    .i_wbeat (r_wr_cnt),
    .i_wdata (w_wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rd1)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (valid_in) begin
      if (w_wr_last) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= !r_wr_bank;
      end else begin
        r_wr_cnt <= r_wr_cnt + BEAT_W'(1);
      end
    end
  end

  // Set after clear: a bank completing its fill always ends up flagged ready.
  always_comb begin
    w_ready_nxt = r_ready;
    if (w_rd_done) w_ready_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_ready_nxt[r_wr_bank] = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_done     = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (r_ready[r_rd_bank]) begin
          w_state_nxt  = RD_READ;
          w_rd_cnt_nxt = '0;
        end
      end
      RD_READ: begin
        if (r_rd_cnt == LAST_BEAT) begin
          w_rd_done     = 1'b1;
          w_rd_cnt_nxt  = '0;
          w_rd_bank_nxt = !r_rd_bank;
          if (!r_ready[!r_rd_bank]) w_state_nxt = RD_IDLE;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + BEAT_W'(1);
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RD_IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_ready   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < NCHAN; l++) begin
      w_rd_e[l] = r_rd_bank ? entry_t'(w_rd1[l]) : entry_t'(w_rd0[l]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_out <= 1'b0;
      r_sof_out   <= 1'b0;
      r_re_out    <= '0;
      r_im_out    <= '0;
      r_idx_out   <= '0;
    end else begin
      r_valid_out <= (r_state == RD_READ);
      r_sof_out   <= (r_state == RD_READ) && (r_rd_cnt == '0);
      for (int unsigned l = 0; l < NCHAN; l++) begin
        r_re_out[l]  <= (r_state == RD_READ) ? w_rd_e[l].re  : '0;
        r_im_out[l]  <= (r_state == RD_READ) ? w_rd_e[l].im  : '0;
        r_idx_out[l] <= (r_state == RD_READ) ? w_rd_e[l].idx : '0;
      end
    end
  end

  assign valid_out   = r_valid_out;
  assign sof_out     = r_sof_out;
  assign data_re_out = r_re_out;
  assign data_im_out = r_im_out;
  assign idx_out     = r_idx_out;

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Directed bench for bitrev_reorder_buf: single frame, back-to-back frames,
// gapped input and resets mid-frame / mid-read, checked against hand values.
module tb_bitrev_reorder_buf;

  localparam int NCHAN  = 16;
  localparam int DATA_W = 12;
  localparam int IDX_W  = 5;
  localparam int BEATS  = 32;
  localparam int CAP    = 256;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic valid_in = 1'b0;
  logic signed [NCHAN-1:0][DATA_W-1:0] data_re_in, data_im_in, data_re_out, data_im_out;
  logic signed [NCHAN-1:0][IDX_W-1:0]  idx_in, idx_out;
  logic valid_out, sof_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cap_n = 0;
  int nz_bad = 0;
  int cap_cyc [CAP];
  logic cap_sof [CAP];
  logic signed [DATA_W-1:0] cap_re  [CAP][NCHAN];
  logic signed [DATA_W-1:0] cap_im  [CAP][NCHAN];
  logic signed [IDX_W-1:0]  cap_idx [CAP][NCHAN];

  int exp_b0_re [16] = '{0, 256, 128, 384, 64, 320, 192, 448,
                         32, 288, 160, 416, 96, 352, 224, 480};

  bitrev_reorder_buf #(
    .N_FFT  (512),
    .NCHAN  (NCHAN),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid_in    (valid_in),
    .data_re_in  (data_re_in),
    .data_im_in  (data_im_in),
    .idx_in      (idx_in),
    .data_re_out (data_re_out),
    .data_im_out (data_im_out),
    .idx_out     (idx_out),
    .valid_out   (valid_out),
    .sof_out     (sof_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) begin
      if (cap_n < CAP) begin
        cap_cyc[cap_n] = cyc;
        cap_sof[cap_n] = sof_out;
        for (int l = 0; l < NCHAN; l++) begin
          cap_re[cap_n][l]  = data_re_out[l];
          cap_im[cap_n][l]  = data_im_out[l];
          cap_idx[cap_n][l] = idx_out[l];
        end
      end
      cap_n = cap_n + 1;
    end else if (sof_out || data_re_out != '0 || data_im_out != '0 || idx_out != '0) begin
      nz_bad = nz_bad + 1;
    end
  end

  function automatic int brev9(input int x);
    int y = 0;
    for (int i = 0; i < 9; i++) if (x[i]) y = y | (1 << (8 - i));
    return y;
  endfunction

  function automatic int s_re(input int f, input int n);
    case (f)
      0: return n;
      1: return 1000 - n;
      default: return (n * 7) % 4096 - 2048;
    endcase
  endfunction

  function automatic int s_im(input int f, input int n);
    case (f)
      0: return -n;
      1: return 3 * n - 700;
      default: return 2047 - n * 5;
    endcase
  endfunction

  function automatic int s_idx(input int f, input int n);
    case (f)
      0: return n % 16;
      1: return (n % 32) - 16;
      default: return 15 - (n % 32);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put_beat(input int f, input int w);
    valid_in = 1'b1;
    for (int l = 0; l < NCHAN; l++) begin
      data_re_in[l] = DATA_W'(s_re(f, w * NCHAN + l));
      data_im_in[l] = DATA_W'(s_im(f, w * NCHAN + l));
      idx_in[l]     = IDX_W'(s_idx(f, w * NCHAN + l));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    valid_in   = 1'b0;
    data_re_in = '0;
    data_im_in = '0;
    idx_in     = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int f);
    int n;
    for (int r = 0; r < BEATS; r++) begin
      if (base + r < CAP) begin
        chk({tag, "_sof"}, int'(cap_sof[base + r]), (r == 0) ? 1 : 0);
        for (int l = 0; l < NCHAN; l++) begin
          n = brev9(r * NCHAN + l);
          chk({tag, "_re"},  int'(cap_re[base + r][l]),  s_re(f, n));
          chk({tag, "_im"},  int'(cap_im[base + r][l]),  s_im(f, n));
          chk({tag, "_idx"}, int'(cap_idx[base + r][l]), s_idx(f, n));
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_sof"}, int'(sof_out), 0);
    chk({tag, "_data_nz"}, int'(data_re_out != '0 || data_im_out != '0 || idx_out != '0), 0);
  endtask

  initial begin
    int base, base2, t_last, w, k;
    data_re_in = '0;
    data_im_in = '0;
    idx_in     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle_cycles(2);

    // single ramp frame
    base = cap_n;
    for (int i = 0; i < BEATS; i++) put_beat(0, i);
    t_last = cyc;
    idle_cycles(40);
    chk("t1_count", cap_n - base, 32);
    chk("t1_latency", cap_cyc[base] - t_last, 2);
    chk("t1_contig", cap_cyc[base + 31] - cap_cyc[base], 31);
    for (int l = 0; l < NCHAN; l++) chk("t1_beat0_re", int'(cap_re[base][l]), exp_b0_re[l]);
    check_frame("t1", base, 0);

    // back-to-back frames
    base = cap_n;
    t_last = 0;
    for (int i = 0; i < 2 * BEATS; i++) begin
      put_beat((i < BEATS) ? 1 : 2, i % BEATS);
      if (i == BEATS - 1) t_last = cyc;
    end
    idle_cycles(80);
    chk("t2_count", cap_n - base, 64);
    chk("t2_latency", cap_cyc[base] - t_last, 2);
    chk("t2_contig", cap_cyc[base + 63] - cap_cyc[base], 63);
    check_frame("t2a", base, 1);
    check_frame("t2b", base + 32, 2);

    // every third cycle idle
    base = cap_n;
    w = 0;
    k = 0;
    while (w < BEATS) begin
      if (k % 3 == 2) idle_cycles(1);
      else begin
        put_beat(0, w);
        w++;
      end
      k++;
    end
    t_last = cyc;
    idle_cycles(40);
    chk("t3_count", cap_n - base, 32);
    chk("t3_latency", cap_cyc[base] - t_last, 2);
    chk("t3_contig", cap_cyc[base + 31] - cap_cyc[base], 31);
    check_frame("t3", base, 0);

    // reset after 10 beats of a frame
    for (int i = 0; i < 10; i++) put_beat(1, i);
    rstn = 1'b0;
    idle_cycles(0);
    @(negedge clk);
    check_reset_outputs("t4_rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    base = cap_n;
    for (int i = 0; i < BEATS; i++) put_beat(2, i);
    t_last = cyc;
    idle_cycles(40);
    chk("t4_count", cap_n - base, 32);
    chk("t4_latency", cap_cyc[base] - t_last, 2);
    check_frame("t4", base, 2);

    // reset while a frame is being read out
    base = cap_n;
    for (int i = 0; i < BEATS; i++) put_beat(1, i);
    for (int i = 0; i < 60 && cap_n < base + 5; i++) idle_cycles(1);
    chk("t5_started", int'(cap_n >= base + 5), 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    base2 = cap_n;
    idle_cycles(40);
    chk("t5_flushed", cap_n - base2, 0);
    base = cap_n;
    for (int i = 0; i < BEATS; i++) put_beat(0, i);
    t_last = cyc;
    idle_cycles(40);
    chk("t5_count", cap_n - base, 32);
    chk("t5_latency", cap_cyc[base] - t_last, 2);
    check_frame("t5", base, 0);

    chk("idle_zero", nz_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
